// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_pkg : shared encodings for the pipeline hazard unit  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M wins over W; x0 is hardwired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl : stall/flush/forward control for the 5-stage core   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rs1E,
  input  logic [REG_ADDR_W-1:0] rs2E,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regwriteM,
  input  logic                  regwriteW,
  input  logic                  loadE,
  input  logic                  pcsrcE,
  input  logic                  memreqM,
  input  logic                  mem_ready,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushW,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  hz_state_t r_state;
  hz_state_t w_next_state;
  logic      w_memwait;
  logic      w_lwstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_memwait    = 1'b0;
    w_lwstall    = 1'b0;
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushW       = 1'b0;
    forwardAE    = FWD_RF;
    forwardBE    = FWD_RF;

    // Outputs are forced quiet while reset is held.
    if (reset) begin
      case (r_state)
        RUN: begin
          if (memreqM && !mem_ready) begin
            w_next_state = MEMWAIT;
            w_memwait    = 1'b1;
          end
        end
        MEMWAIT: begin
          if (mem_ready) begin
            w_next_state = RUN;
          end else begin
            w_memwait = 1'b1;
          end
        end
        default: w_next_state = RUN;
      endcase

      w_lwstall = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

      if (w_memwait) begin
        // Whole pipe frozen; M/W gets a bubble so W does not retire twice.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        // The D instruction is on the wrong path, so a load-use stall is moot.
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (w_lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end

      forwardAE = fwd_sel(rs1E, rdM, regwriteM, rdW, regwriteW);
      forwardBE = fwd_sel(rs2E, rdM, regwriteM, rdW, regwriteW);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (stallF),
    .o_count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (flushD),
    .o_count (flush_cnt)
  );

endmodule
`default_nettype wire
